// File: rtl/circuito_seg7_pkg.sv
// Shared types and glyph constants for the single-digit seven-segment decoder.
// Segment vectors are ordered {a,b,c,d,e,f,g}, MSB = a.
package circuito_seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0   = 7'b1111110;
    localparam seg_t SEG_1   = 7'b0110000;
    localparam seg_t SEG_2   = 7'b1101101;
    localparam seg_t SEG_3   = 7'b1111001;
    localparam seg_t SEG_4   = 7'b0110011;
    localparam seg_t SEG_5   = 7'b1011011;
    localparam seg_t SEG_6   = 7'b1011111;
    localparam seg_t SEG_7   = 7'b1110000;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1111011;
    localparam seg_t SEG_OFF = 7'b0000000;

    // Units digit of a 0..31 value; at most three tens can be stripped.
    function automatic logic [3:0] mod10(input logic [4:0] v);
        logic [4:0] r;
        if (v >= 5'd30)
            r = v - 5'd30;
        else if (v >= 5'd20)
            r = v - 5'd20;
        else if (v >= 5'd10)
            r = v - 5'd10;
        else
            r = v;
        return r[3:0];
    endfunction

endpackage

// File: rtl/circuito_seg7_if.sv
// Value bits in (b1 = MSB .. b5 = LSB) and segment lines out for one display digit.
interface circuito_seg7_if;

    logic b1, b2, b3, b4, b5;
    logic a, b, c, d, e, f, g;

    modport master (
        output b1, b2, b3, b4, b5,
        input  a, b, c, d, e, f, g
    );

    modport slave (
        input  b1, b2, b3, b4, b5,
        output a, b, c, d, e, f, g
    );

endinterface

// File: rtl/circuito_seg7_digit_rom.sv
// Combinational digit-to-glyph lookup, active-high; codes 10..15 are blank.
module seg7_digit_rom
    import circuito_seg7_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (digit)
            4'd0: glyph = SEG_0;
            4'd1: glyph = SEG_1;
            4'd2: glyph = SEG_2;
            4'd3: glyph = SEG_3;
            4'd4: glyph = SEG_4;
            4'd5: glyph = SEG_5;
            4'd6: glyph = SEG_6;
            4'd7: glyph = SEG_7;
            4'd8: glyph = SEG_8;
            4'd9: glyph = SEG_9;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/circuito_seg7.sv
// Registered decoder: 5-bit value -> units digit shown on one seven-segment display.
// SEG_ACTIVE_HIGH=0 inverts every segment for common-anode parts.
module circuito_seg7
    import circuito_seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    circuito_seg7_if.slave    sif
);

    localparam seg_t OFF_LEVEL = SEG_ACTIVE_HIGH ? SEG_OFF : ~SEG_OFF;

    logic [4:0] value;
    logic [3:0] digit;
    seg_t       glyph;
    seg_t       seg_nxt;
    seg_t       seg_q;

    assign value = {sif.b1, sif.b2, sif.b3, sif.b4, sif.b5};
    assign digit = mod10(value);

    seg7_digit_rom u_rom (
        .digit (digit),
        .glyph (glyph)
    );

    assign seg_nxt = SEG_ACTIVE_HIGH ? glyph : ~glyph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seg_q <= OFF_LEVEL;
        else
            seg_q <= seg_nxt;
    end

    assign {sif.a, sif.b, sif.c, sif.d, sif.e, sif.f, sif.g} = seg_q;

endmodule

// File: tb/tb_circuito_seg7.sv
// Directed bench: active-high and active-low decoders side by side, shared clock/reset.
module tb_circuito_seg7;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;

    // Hand-written glyph table, {a..g}, active-high.
    logic [6:0] exp_glyph [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    circuito_seg7_if hi_if ();
    circuito_seg7_if lo_if ();

    circuito_seg7 #(.SEG_ACTIVE_HIGH(1'b1)) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (hi_if.slave)
    );

    circuito_seg7 #(.SEG_ACTIVE_HIGH(1'b0)) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (lo_if.slave)
    );

    logic [6:0] hi_seg;
    logic [6:0] lo_seg;
    assign hi_seg = {hi_if.a, hi_if.b, hi_if.c, hi_if.d, hi_if.e, hi_if.f, hi_if.g};
    assign lo_seg = {lo_if.a, lo_if.b, lo_if.c, lo_if.d, lo_if.e, lo_if.f, lo_if.g};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_v(input logic [4:0] v);
        {hi_if.b1, hi_if.b2, hi_if.b3, hi_if.b4, hi_if.b5} = v;
        {lo_if.b1, lo_if.b2, lo_if.b3, lo_if.b4, lo_if.b5} = v;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_v(5'd8);

        // Reset held with V=8: both decoders stay at their off level.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_hold_hi", hi_seg, 7'b0000000);
            check("rst_hold_lo", lo_seg, 7'b1111111);
        end
        rst_n = 1'b1;
        step();
        check("rst_rel_hi", hi_seg, 7'b1111111);
        check("rst_rel_lo", lo_seg, 7'b0000000);

        // Full sweep, one value per clock, checked one edge later.
        for (int v = 0; v < 32; v++) begin
            set_v(v[4:0]);
            step();
            check($sformatf("sweep_hi_%0d", v), hi_seg, exp_glyph[v % 10]);
            check($sformatf("sweep_lo_%0d", v), lo_seg, ~exp_glyph[v % 10]);
        end

        // Spot values from the table, hand-computed.
        set_v(5'd16); step(); check("v16", hi_seg, 7'b1011111);
        set_v(5'd25); step(); check("v25", hi_seg, 7'b1011011);
        set_v(5'd31); step(); check("v31", hi_seg, 7'b0110000);
        set_v(5'd10); step(); check("v10", hi_seg, 7'b1111110);

        // Latency: change between edges has no effect until the next edge.
        set_v(5'd3);
        step();
        check("lat_before", hi_seg, 7'b1111001);
        set_v(5'd7);
        #3;
        check("lat_hold", hi_seg, 7'b1111001);
        step();
        check("lat_after", hi_seg, 7'b1110000);

        // Mid-operation reset asserted and released between edges.
        set_v(5'd2);
        step();
        check("mid_pre", hi_seg, 7'b1101101);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_hi", hi_seg, 7'b0000000);
        check("mid_async_lo", lo_seg, 7'b1111111);
        #2 rst_n = 1'b1;
        #1;
        check("mid_still_off", hi_seg, 7'b0000000);
        step();
        check("mid_back", hi_seg, 7'b1101101);

        // Polarity: common-anode decoder with V=1.
        set_v(5'd1);
        step();
        check("pol_lo_v1", lo_seg, 7'b1001111);
        check("pol_hi_v1", hi_seg, 7'b0110000);

        // Glitch on b1 while V=4 never reaches the outputs.
        set_v(5'd4);
        step();
        check("glitch_pre", hi_seg, 7'b0110011);
        #2 hi_if.b1 = 1'b1;
        #3 hi_if.b1 = 1'b0;
        #1;
        check("glitch_mid", hi_seg, 7'b0110011);
        step();
        check("glitch_post", hi_seg, 7'b0110011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
